elh_bound_check_pipe: RTL and testbench

- Pipelined, parametrised ELH bounds checker for load/store pointer accesses.
- Each request carries an 8-bit ELH tag, a pointer address and an access size.
- Stage 1 decodes the tag into tolerant and allocation bounds; stage 2 classifies the access as OK, tolerant-zone, out-of-bounds or tag error.
- Sits between the LSU address stage and the exception/CSR logic; generalises the fixed 24-bit decoder to ADDR_W bits with valid/ready flow control and a violation counter.

---
 rtl/elh_pkg.sv | 35 +++
 rtl/elh_tag_decode.sv | 86 ++++++++
 rtl/elh_bound_check_pipe.sv | 140 ++++++++++++++
 tb/tb_elh_bound_check_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elh_pkg.sv
// Shared types and tag field helpers for the ELH bounds-check pipeline.
// Bound fields are sized for the widest legal address; narrower instances zero-extend.
package elh_pkg;

   localparam int ELH_MAX_AW = 32;

   typedef enum logic [1:0] {
      ELH_OK     = 2'd0,
      ELH_TOL    = 2'd1,
      ELH_OOB    = 2'd2,
      ELH_TAGERR = 2'd3
   } elh_status_e;

   typedef struct packed {
      logic [ELH_MAX_AW-1:0] tol_start;
      logic [ELH_MAX_AW-1:0] tol_end;
      logic [ELH_MAX_AW-1:0] alloc_start;
      logic [ELH_MAX_AW-1:0] alloc_end;
      logic                  tag_err;
   } elh_bounds_t;

   // Tag layout is {e4,e3,l1,l0,h,e2,e1,e0}
   function automatic logic [4:0] elh_tag_e(input logic [7:0] tag);
      return {tag[7:6], tag[2:0]};
   endfunction

   function automatic logic [1:0] elh_tag_l(input logic [7:0] tag);
      return tag[5:4];
   endfunction

   function automatic logic elh_tag_h(input logic [7:0] tag);
      return tag[3];
   endfunction

endpackage

// File: rtl/elh_tag_decode.sv
// Combinational ELH tag decoder: tag + pointer address -> tolerant and allocation bounds.
// Arithmetic runs 4 bits wider than the address so base<<e never overflows before truncation.
module elh_tag_decode
   import elh_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int ESAT   = ADDR_W - 2
) (
   input  logic [7:0]        i_tag,
   input  logic [ADDR_W-1:0] i_addr,
   output elh_bounds_t       o_bounds
);

   localparam int AW4 = ADDR_W + 4;
   localparam logic [4:0] ESAT_V = 5'(ESAT);

   logic [4:0]     w_e;
   logic [1:0]     w_l;
   logic           w_h;
   logic [5:0]     w_eAmend;
   logic [3:0]     w_lb;
   logic [3:0]     w_ub;
   logic [3:0]     w_base;
   logic           w_tagErr;
   logic [AW4-1:0] w_addrExt;
   logic [AW4-1:0] w_mask;
   logic [AW4-1:0] w_tolStart;
   logic [AW4-1:0] w_tolEnd;
   logic [AW4-1:0] w_allocStart;
   logic [AW4-1:0] w_allocEnd;

   assign w_e = elh_tag_e(i_tag);
   assign w_l = elh_tag_l(i_tag);
   assign w_h = elh_tag_h(i_tag);

   // At the saturation exponent the L/H codes extend the exponent instead of the base
   always_comb begin
      w_eAmend = {1'b0, w_e};
      w_lb     = 4'd0;
      w_ub     = 4'd1;
      w_base   = 4'd1;
      w_tagErr = 1'b0;
      if (i_tag == 8'h00 || w_e > ESAT_V) begin
         w_tagErr = 1'b1;
      end else if (w_e == ESAT_V) begin
         case ({w_l, w_h})
            3'b001: begin w_lb = 4'd0; w_ub = 4'd1; w_base = 4'd1; end
            3'b011: begin w_eAmend = {1'b0, w_e} + 6'd1; w_lb = 4'd0; w_ub = 4'd1; w_base = 4'd1; end
            3'b100: begin w_lb = 4'd1; w_ub = 4'd4; w_base = 4'd4; end
            3'b101: begin w_lb = 4'd0; w_ub = 4'd3; w_base = 4'd4; end
            3'b111: begin w_eAmend = {1'b0, w_e} + 6'd2; w_lb = 4'd0; w_ub = 4'd1; w_base = 4'd1; end
            default: w_tagErr = 1'b1;
         endcase
      end else begin
         case ({w_l, w_h})
            3'b001: begin w_lb = 4'd0; w_ub = 4'd1; w_base = 4'd1; end
            3'b010: begin w_lb = 4'd1; w_ub = 4'd4; w_base = 4'd4; end
            3'b011: begin w_lb = 4'd0; w_ub = 4'd3; w_base = 4'd4; end
            3'b100: begin w_lb = 4'd3; w_ub = 4'd8; w_base = 4'd8; end
            3'b101: begin w_lb = 4'd0; w_ub = 4'd5; w_base = 4'd8; end
            3'b110: begin w_lb = 4'd1; w_ub = 4'd8; w_base = 4'd8; end
            3'b111: begin w_lb = 4'd0; w_ub = 4'd7; w_base = 4'd8; end
            default: w_tagErr = 1'b1;
         endcase
      end
   end

   assign w_addrExt    = AW4'(i_addr);
   assign w_mask       = (AW4'(w_base) << w_eAmend) - AW4'(1);
   assign w_tolStart   = w_addrExt & ~w_mask;
   assign w_tolEnd     = w_tolStart | w_mask;
   assign w_allocStart = w_tolStart | (AW4'(w_lb) << w_eAmend);
   assign w_allocEnd   = w_tolStart | ((AW4'(w_ub) << w_eAmend) - AW4'(1));

   always_comb begin
      o_bounds = '0;
      o_bounds.tag_err = w_tagErr;
      if (!w_tagErr) begin
         o_bounds.tol_start   = ELH_MAX_AW'(w_tolStart[ADDR_W-1:0]);
         o_bounds.tol_end     = ELH_MAX_AW'(w_tolEnd[ADDR_W-1:0]);
         o_bounds.alloc_start = ELH_MAX_AW'(w_allocStart[ADDR_W-1:0]);
         o_bounds.alloc_end   = ELH_MAX_AW'(w_allocEnd[ADDR_W-1:0]);
      end
   end

endmodule

// File: rtl/elh_bound_check_pipe.sv
// Two-stage ELH bounds checker: stage 1 registers decoded bounds, stage 2 registers the
// access classification. Valid/ready on both sides plus a saturating violation counter.
module elh_bound_check_pipe
   import elh_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int ESAT   = ADDR_W - 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [7:0]        req_tag_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [1:0]        req_size_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [1:0]        resp_status_o,
   output logic [ADDR_W-1:0] resp_alloc_start_o,
   output logic [ADDR_W-1:0] resp_alloc_end_o,
   output logic [ADDR_W-1:0] resp_tol_start_o,
   output logic [ADDR_W-1:0] resp_tol_end_o,
   output logic [CNT_W-1:0]  viol_cnt_o,
   input  logic              cnt_clr_i
);

   localparam int LW = ADDR_W + 1;

   logic              r_s1Valid;
   logic [ADDR_W-1:0] r_s1Addr;
   logic [1:0]        r_s1Size;
   elh_bounds_t       r_s1Bounds;

   logic              r_s2Valid;
   elh_status_e       r_s2Status;
   logic [ADDR_W-1:0] r_s2TolStart;
   logic [ADDR_W-1:0] r_s2TolEnd;
   logic [ADDR_W-1:0] r_s2AllocStart;
   logic [ADDR_W-1:0] r_s2AllocEnd;

   logic [CNT_W-1:0]  r_violCnt;

   elh_bounds_t       w_decBounds;
   logic              w_s2Take;
   logic              w_s1Load;
   logic [LW-1:0]     w_sizeBytes;
   logic [LW-1:0]     w_last;
   logic [ADDR_W-1:0] w_tolEnd;
   logic [ADDR_W-1:0] w_allocStart;
   logic [ADDR_W-1:0] w_allocEnd;
   elh_status_e       w_s1Status;
   logic              w_violHs;

   assign w_s2Take    = !r_s2Valid | resp_ready_i;
   assign w_s1Load    = !r_s1Valid | w_s2Take;
   assign req_ready_o = w_s1Load & !rst_i;

   elh_tag_decode #(
      .ADDR_W (ADDR_W),
      .ESAT   (ESAT)
   ) u_tagDecode (
      .i_tag    (req_tag_i),
      .i_addr   (req_addr_i),
      .o_bounds (w_decBounds)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1Valid  <= 1'b0;
         r_s1Addr   <= '0;
         r_s1Size   <= '0;
         r_s1Bounds <= '0;
      end else if (w_s1Load) begin
         r_s1Valid <= req_valid_i;
         if (req_valid_i) begin
            r_s1Addr   <= req_addr_i;
            r_s1Size   <= req_size_i;
            r_s1Bounds <= w_decBounds;
         end
      end
   end

   // The extra top bit of w_last catches accesses that wrap past the end of the address space
   assign w_sizeBytes  = LW'(1) << r_s1Size;
   assign w_last       = {1'b0, r_s1Addr} + w_sizeBytes - LW'(1);
   assign w_tolEnd     = r_s1Bounds.tol_end[ADDR_W-1:0];
   assign w_allocStart = r_s1Bounds.alloc_start[ADDR_W-1:0];
   assign w_allocEnd   = r_s1Bounds.alloc_end[ADDR_W-1:0];

   always_comb begin
      w_s1Status = ELH_OK;
      if (r_s1Bounds.tag_err) begin
         w_s1Status = ELH_TAGERR;
      end else if (w_last[ADDR_W] || w_last[ADDR_W-1:0] > w_tolEnd) begin
         w_s1Status = ELH_OOB;
      end else if (r_s1Addr < w_allocStart || w_last[ADDR_W-1:0] > w_allocEnd) begin
         w_s1Status = ELH_TOL;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s2Valid      <= 1'b0;
         r_s2Status     <= ELH_OK;
         r_s2TolStart   <= '0;
         r_s2TolEnd     <= '0;
         r_s2AllocStart <= '0;
         r_s2AllocEnd   <= '0;
      end else if (w_s2Take) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Status     <= w_s1Status;
            r_s2TolStart   <= r_s1Bounds.tol_start[ADDR_W-1:0];
            r_s2TolEnd     <= w_tolEnd;
            r_s2AllocStart <= w_allocStart;
            r_s2AllocEnd   <= w_allocEnd;
         end
      end
   end

   assign w_violHs = r_s2Valid & resp_ready_i & (r_s2Status != ELH_OK);

   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
         r_violCnt <= '0;
      end else if (w_violHs && !(&r_violCnt)) begin
         r_violCnt <= r_violCnt + CNT_W'(1);
      end
   end

   assign resp_valid_o       = r_s2Valid;
   assign resp_status_o      = r_s2Status;
   assign resp_tol_start_o   = r_s2TolStart;
   assign resp_tol_end_o     = r_s2TolEnd;
   assign resp_alloc_start_o = r_s2AllocStart;
   assign resp_alloc_end_o   = r_s2AllocEnd;
   assign viol_cnt_o         = r_violCnt;

endmodule

// File: tb/tb_elh_bound_check_pipe.sv
// Randomised and directed bench for elh_bound_check_pipe, scored against an arithmetic
// model of the ELH bound rules and an occupancy-based model of the handshake.
module tb_elh_bound_check_pipe;

   localparam int ADDR_W  = 32;
   localparam int ESAT_TB = 30;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int LB_LO[8]   = '{0, 0, 1, 0, 3, 0, 1, 0};
   localparam int UB_LO[8]   = '{0, 1, 4, 3, 8, 5, 8, 7};
   localparam int BASE_LO[8] = '{0, 1, 4, 4, 8, 8, 8, 8};
   localparam int EADD_HI[8] = '{0, 0, 0, 1, 0, 0, 0, 2};
   localparam int LB_HI[8]   = '{0, 0, 0, 0, 1, 0, 0, 0};
   localparam int UB_HI[8]   = '{0, 1, 0, 1, 4, 3, 0, 1};
   localparam int BASE_HI[8] = '{0, 1, 0, 1, 4, 4, 0, 1};

   typedef struct packed {
      logic [1:0]  status;
      logic [31:0] tolS;
      logic [31:0] tolE;
      logic [31:0] allocS;
      logic [31:0] allocE;
   } expResp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              reqValid;
   logic              reqReady;
   logic [7:0]        reqTag;
   logic [ADDR_W-1:0] reqAddr;
   logic [1:0]        reqSize;
   logic              respValid;
   logic              respReady;
   logic [1:0]        respStatus;
   logic [ADDR_W-1:0] allocStart;
   logic [ADDR_W-1:0] allocEnd;
   logic [ADDR_W-1:0] tolStart;
   logic [ADDR_W-1:0] tolEnd;
   logic [CNT_W-1:0]  violCnt;
   logic              cntClr;

   int       checks = 0;
   int       failures = 0;
   int       modelCnt = 0;
   bit       lastAccept;
   expResp_t sbQ[$];

   always #5 clk = ~clk;

   elh_bound_check_pipe #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (reqValid),
      .req_ready_o        (reqReady),
      .req_tag_i          (reqTag),
      .req_addr_i         (reqAddr),
      .req_size_i         (reqSize),
      .resp_valid_o       (respValid),
      .resp_ready_i       (respReady),
      .resp_status_o      (respStatus),
      .resp_alloc_start_o (allocStart),
      .resp_alloc_end_o   (allocEnd),
      .resp_tol_start_o   (tolStart),
      .resp_tol_end_o     (tolEnd),
      .viol_cnt_o         (violCnt),
      .cnt_clr_i          (cntClr)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Bounds come from aligning the address down to a block of base*2^e bytes
   function automatic expResp_t refModel(input logic [7:0] tag, input logic [31:0] addr, input logic [1:0] size);
      expResp_t r;
      int e, code, eam, lb, ub, base;
      bit bad;
      longint unsigned scale, block, tolS, a, last, aS, aE;
      r    = '0;
      e    = int'({tag[7:6], tag[2:0]});
      code = int'(tag[5:3]);
      eam = 0; lb = 0; ub = 0; base = 1;
      bad  = (tag == 8'h00) || (e > ESAT_TB);
      if (!bad && e < ESAT_TB) begin
         bad = (code == 0);
         eam = e; lb = LB_LO[code]; ub = UB_LO[code]; base = BASE_LO[code];
      end else if (!bad) begin
         bad = !(code inside {1, 3, 4, 5, 7});
         eam = e + EADD_HI[code]; lb = LB_HI[code]; ub = UB_HI[code]; base = BASE_HI[code];
      end
      if (bad) begin
         r.status = 2'd3;
         return r;
      end
      scale = 64'd1 << eam;
      block = longint'(base) * scale;
      a     = 64'(addr);
      tolS  = (a / block) * block;
      aS    = tolS + longint'(lb) * scale;
      aE    = tolS + longint'(ub) * scale - 1;
      last  = a + (64'd1 << size) - 1;
      r.tolS   = 32'(tolS);
      r.tolE   = 32'(tolS + block - 1);
      r.allocS = 32'(aS);
      r.allocE = 32'(aE);
      if (last > 64'hFFFF_FFFF || last > tolS + block - 1) r.status = 2'd2;
      else if (a < aS || last > aE)                       r.status = 2'd1;
      else                                                r.status = 2'd0;
      return r;
   endfunction

   // Called at the falling edge: scores what the next rising edge will do
   task automatic monitor();
      bit expReady, hs, violHs;
      expReady = !rst && (sbQ.size() < 2 || respReady);
      checkOutput("req_ready", 64'(reqReady), 64'(expReady));
      checkOutput("viol_cnt", 64'(violCnt), 64'(modelCnt));
      lastAccept = 1'b0;
      if (rst) begin
         sbQ.delete();
         modelCnt = 0;
         return;
      end
      hs = 1'b0;
      violHs = 1'b0;
      if (respValid) begin
         if (sbQ.size() == 0) begin
            checkOutput("resp_valid_spurious", 64'(respValid), 64'd0);
         end else begin
            checkOutput("status", 64'(respStatus), 64'(sbQ[0].status));
            checkOutput("tol_start", 64'(tolStart), 64'(sbQ[0].tolS));
            checkOutput("tol_end", 64'(tolEnd), 64'(sbQ[0].tolE));
            checkOutput("alloc_start", 64'(allocStart), 64'(sbQ[0].allocS));
            checkOutput("alloc_end", 64'(allocEnd), 64'(sbQ[0].allocE));
            hs = respReady;
            violHs = hs && (sbQ[0].status != 2'd0);
         end
      end
      if (cntClr) modelCnt = 0;
      else if (violHs && modelCnt < CNT_MAX) modelCnt++;
      if (hs) void'(sbQ.pop_front());
      if (reqValid && reqReady) begin
         sbQ.push_back(refModel(reqTag, reqAddr, reqSize));
         lastAccept = 1'b1;
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] tag, input logic [31:0] addr, input logic [1:0] size);
      reqValid = 1'b1;
      reqTag   = tag;
      reqAddr  = addr;
      reqSize  = size;
   endtask

   // Single request into an empty pipe with literal expectations two cycles later
   task automatic sendAndCheck(input string name, input logic [7:0] tag, input logic [31:0] addr,
                               input logic [1:0] size, input logic [1:0] expStatus,
                               input logic [31:0] expTolS, input logic [31:0] expTolE,
                               input logic [31:0] expAllocS, input logic [31:0] expAllocE);
      respReady = 1'b1;
      applyStimulus(tag, addr, size);
      stepCycle();
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput({name, "_early"}, 64'(respValid), 64'd0);
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput({name, "_valid"}, 64'(respValid), 64'd1);
      checkOutput({name, "_status"}, 64'(respStatus), 64'(expStatus));
      checkOutput({name, "_tolS"}, 64'(tolStart), 64'(expTolS));
      checkOutput({name, "_tolE"}, 64'(tolEnd), 64'(expTolE));
      checkOutput({name, "_allocS"}, 64'(allocStart), 64'(expAllocS));
      checkOutput({name, "_allocE"}, 64'(allocEnd), 64'(expAllocE));
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      reqValid  = 1'b0;
      respReady = 1'b1;
      for (int i = 0; i < 20 && sbQ.size() != 0; i++) stepCycle();
      checkOutput("drain_left", 64'(sbQ.size()), 64'd0);
   endtask

   initial begin
      logic [7:0]  tagR;
      logic [31:0] addrR;
      int accepted;
      rst = 1'b1; reqValid = 1'b0; reqTag = '0; reqAddr = '0; reqSize = '0;
      respReady = 1'b0; cntClr = 1'b0;
      repeat (3) stepCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
      checkOutput("rst_status", 64'(respStatus), 64'd0);
      checkOutput("rst_bounds", {tolStart, allocEnd}, 64'd0);
      checkOutput("rst_cnt", 64'(violCnt), 64'd0);
      monitor();
      @(posedge clk);
      #1;

      sendAndCheck("ok", 8'h14, 32'h1000_0010, 2'd2, 2'd0, 32'h1000_0000, 32'h1000_003F, 32'h1000_0010, 32'h1000_003F);
      sendAndCheck("tol", 8'h14, 32'h1000_0008, 2'd2, 2'd1, 32'h1000_0000, 32'h1000_003F, 32'h1000_0010, 32'h1000_003F);
      sendAndCheck("oob", 8'h14, 32'h1000_003C, 2'd3, 2'd2, 32'h1000_0000, 32'h1000_003F, 32'h1000_0010, 32'h1000_003F);
      sendAndCheck("tag0", 8'h00, 32'h1234_5678, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);
      sendAndCheck("e31", 8'hDF, 32'h1234_5678, 2'd1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);
      sendAndCheck("esat", 8'hFE, 32'h1234_5678, 2'd2, 2'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
      sendAndCheck("wrap", 8'h14, 32'hFFFF_FFFC, 2'd3, 2'd2, 32'hFFFF_FFC0, 32'hFFFF_FFFF, 32'hFFFF_FFD0, 32'hFFFF_FFFF);
      sendAndCheck("e22", 8'hBE, 32'h1234_5678, 2'd2, 2'd0, 32'h1200_0000, 32'h13FF_FFFF, 32'h1200_0000, 32'h13BF_FFFF);
      drain();
      checkOutput("cnt_directed", 64'(violCnt), 64'd5);

      // Four back-to-back requests against a consumer that stalls for three cycles
      accepted = 0;
      for (int c = 0; c < 20; c++) begin
         respReady = (c >= 3);
         if (c == 3) checkOutput("b2b_accepted_in_stall", 64'(accepted), 64'd2);
         if (accepted < 4) applyStimulus(8'h14 + 8'(accepted), 32'h2000_0000 + 32'(accepted * 8), 2'(accepted));
         else reqValid = 1'b0;
         stepCycle();
         if (lastAccept) accepted++;
      end
      checkOutput("b2b_accepted", 64'(accepted), 64'd4);
      drain();

      for (int c = 0; c < 600; c++) begin
         tagR  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin tagR[7:6] = 2'b11; tagR[2:0] = 3'b110; end
         addrR = $urandom;
         if ($urandom_range(0, 7) == 0) addrR[31:8] = 24'hFFFFFF;
         if ($urandom_range(0, 99) < 70) applyStimulus(tagR, addrR, 2'($urandom_range(0, 3)));
         else reqValid = 1'b0;
         respReady = ($urandom_range(0, 99) < 70);
         cntClr    = ($urandom_range(0, 99) < 2);
         stepCycle();
      end
      cntClr = 1'b0;
      drain();

      cntClr = 1'b1;
      stepCycle();
      cntClr = 1'b0;
      respReady = 1'b1;
      for (int c = 0; c < 300; c++) begin
         applyStimulus(8'h00, 32'($urandom), 2'd0);
         stepCycle();
      end
      drain();
      checkOutput("cnt_saturated", 64'(violCnt), 64'(CNT_MAX));

      // Fill both stages behind a stalled consumer, then reset
      respReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(8'h00, 32'h0, 2'd0);
         stepCycle();
      end
      reqValid = 1'b0;
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_resp_valid", 64'(respValid), 64'd0);
      checkOutput("midrst_cnt", 64'(violCnt), 64'd0);
      monitor();
      @(posedge clk);
      #1;
      respReady = 1'b1;
      repeat (4) stepCycle();

      // Clear coinciding with a violation handshake
      sendAndCheck("pre_clr", 8'h00, 32'h0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);
      applyStimulus(8'h00, 32'h0, 2'd0);
      stepCycle();
      reqValid = 1'b0;
      stepCycle();
      cntClr = 1'b1;
      stepCycle();
      cntClr = 1'b0;
      @(negedge clk);
      checkOutput("cnt_clr_wins", 64'(violCnt), 64'd0);
      monitor();
      @(posedge clk);
      #1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
